// File: rtl/clock_divider_pkg.sv
// Shared helpers for the multi-channel clock divider: index width derivation
// and reset half-period computation.
package clock_divider_pkg;

  function automatic int ceil_log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // A single channel still needs a one-bit select port.
  function automatic int ch_idx_width(input int n);
    return (ceil_log2(n) < 1) ? 1 : ceil_log2(n);
  endfunction

  function automatic longint half_period(input longint ref_clk, input longint freq);
    longint hp;
    if (freq <= 0) return 64'sd1;
    hp = ref_clk / (2 * freq);
    return (hp < 1) ? 64'sd1 : hp;
  endfunction

endpackage

// File: rtl/clock_divider_channel.sv
// One divider channel: half-period counter, active/shadow half-period
// registers, 50% duty output and rising-edge tick.
module clock_divider_channel #(
  parameter int                   DIV_WIDTH  = 32,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_HP = 1
) (
  input  logic                 clk_FPGA,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 restart,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] value,
  output logic                 clock_signal,
  output logic                 tick,
  output logic                 pending
);

  logic [DIV_WIDTH-1:0] counter;
  logic [DIV_WIDTH-1:0] active_hp;
  logic [DIV_WIDTH-1:0] shadow_hp;
  logic [DIV_WIDTH-1:0] next_shadow;
  logic                 next_pending;
  logic                 terminal;

  // shadow equals active whenever nothing is pending, so copying the
  // effective shadow at every boundary is safe.
  always_comb begin
    next_shadow  = load ? value : shadow_hp;
    next_pending = load | pending;
    terminal     = (counter == (active_hp - DIV_WIDTH'(1)));
  end

  always_ff @(posedge clk_FPGA or posedge reset) begin
    if (reset) begin
      counter      <= '0;
      active_hp    <= DEFAULT_HP;
      shadow_hp    <= DEFAULT_HP;
      clock_signal <= 1'b0;
      tick         <= 1'b0;
      pending      <= 1'b0;
    end else begin
      shadow_hp <= next_shadow;
      tick      <= 1'b0;
      if (restart || !enable) begin
        counter      <= '0;
        clock_signal <= 1'b0;
        active_hp    <= next_shadow;
        pending      <= 1'b0;
      end else if (terminal) begin
        counter      <= '0;
        clock_signal <= ~clock_signal;
        tick         <= ~clock_signal;
        active_hp    <= next_shadow;
        pending      <= 1'b0;
      end else begin
        counter <= counter + DIV_WIDTH'(1);
        pending <= next_pending;
      end
    end
  end

endmodule

// File: rtl/clock_divider_multi.sv
// Multi-channel runtime-programmable clock divider: configuration decode,
// load validation and the per-channel divider array.
module clock_divider_multi
  import clock_divider_pkg::*;
#(
  parameter int CHANNELS          = 4,
  parameter int REFERENCE_CLOCK   = 50000000,
  parameter int DEFAULT_FREQUENCY = 1,
  parameter int DIV_WIDTH         = 32,
  localparam int CH_IDX_WIDTH     = ch_idx_width(CHANNELS)
) (
  input  logic                    clk_FPGA,
  input  logic                    reset,
  input  logic [CHANNELS-1:0]     enable,
  input  logic                    sync_restart,
  input  logic                    cfg_load,
  input  logic [CH_IDX_WIDTH-1:0] cfg_channel,
  input  logic [DIV_WIDTH-1:0]    cfg_half_period,
  output logic                    cfg_error,
  output logic [CHANNELS-1:0]     cfg_pending,
  output logic [CHANNELS-1:0]     clock_signal,
  output logic [CHANNELS-1:0]     tick
);

  localparam int CH_SLOTS = 1 << CH_IDX_WIDTH;
  localparam logic [DIV_WIDTH-1:0] DEFAULT_HP =
    DIV_WIDTH'(half_period(REFERENCE_CLOCK, DEFAULT_FREQUENCY));

  logic [CH_SLOTS-1:0] ch_valid;
  logic                cfg_ok;
  logic [CHANNELS-1:0] load_vec;

  // Lookup mask instead of a magnitude compare keeps the range check
  // well-formed when CHANNELS fills the whole index space.
  always_comb begin
    ch_valid = '0;
    for (int i = 0; i < CH_SLOTS; i++) begin
      ch_valid[i] = (i < CHANNELS);
    end
    cfg_ok = (cfg_half_period != '0) && ch_valid[cfg_channel];
  end

  always_ff @(posedge clk_FPGA or posedge reset) begin
    if (reset) begin
      cfg_error <= 1'b0;
    end else begin
      cfg_error <= cfg_load && !cfg_ok;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    assign load_vec[i] = cfg_load && cfg_ok && (cfg_channel == CH_IDX_WIDTH'(i));

    clock_divider_channel #(
      .DIV_WIDTH  (DIV_WIDTH),
      .DEFAULT_HP (DEFAULT_HP)
    ) u_channel (
      .clk_FPGA     (clk_FPGA),
      .reset        (reset),
      .enable       (enable[i]),
      .restart      (sync_restart),
      .load         (load_vec[i]),
      .value        (cfg_half_period),
      .clock_signal (clock_signal[i]),
      .tick         (tick[i]),
      .pending      (cfg_pending[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_multi.sv
// Directed self-checking bench for clock_divider_multi (REFERENCE_CLOCK=100,
// DEFAULT_FREQUENCY=10, so the reset half-period is 5 cycles).
module tb_clock_divider_multi;

  logic        clk_FPGA;
  logic        reset;
  logic [3:0]  enable;
  logic        sync_restart;
  logic        cfg_load;
  logic [1:0]  cfg_channel;
  logic [31:0] cfg_half_period;
  logic        cfg_error;
  logic [3:0]  cfg_pending;
  logic [3:0]  clock_signal;
  logic [3:0]  tick;

  // Three-channel instance exercises the out-of-range channel reject.
  logic [2:0]  enable3;
  logic        cfg_load3;
  logic [1:0]  cfg_channel3;
  logic [31:0] cfg_half_period3;
  logic        cfg_error3;
  logic [2:0]  cfg_pending3;
  logic [2:0]  clock_signal3;
  logic [2:0]  tick3;

  int checks = 0;
  int errors = 0;

  clock_divider_multi #(
    .CHANNELS(4), .REFERENCE_CLOCK(100), .DEFAULT_FREQUENCY(10), .DIV_WIDTH(32)
  ) dut (
    .clk_FPGA(clk_FPGA), .reset(reset), .enable(enable), .sync_restart(sync_restart),
    .cfg_load(cfg_load), .cfg_channel(cfg_channel), .cfg_half_period(cfg_half_period),
    .cfg_error(cfg_error), .cfg_pending(cfg_pending), .clock_signal(clock_signal),
    .tick(tick)
  );

  clock_divider_multi #(
    .CHANNELS(3), .REFERENCE_CLOCK(100), .DEFAULT_FREQUENCY(10), .DIV_WIDTH(32)
  ) dut3 (
    .clk_FPGA(clk_FPGA), .reset(reset), .enable(enable3), .sync_restart(1'b0),
    .cfg_load(cfg_load3), .cfg_channel(cfg_channel3), .cfg_half_period(cfg_half_period3),
    .cfg_error(cfg_error3), .cfg_pending(cfg_pending3), .clock_signal(clock_signal3),
    .tick(tick3)
  );

  initial clk_FPGA = 1'b0;
  always #5 clk_FPGA = ~clk_FPGA;

  task automatic step(input int n);
    repeat (n) @(posedge clk_FPGA);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [1:0] ch, input logic [31:0] hp);
    cfg_load        = 1'b1;
    cfg_channel     = ch;
    cfg_half_period = hp;
  endtask

  initial begin
    reset = 1'b1; enable = 4'hF; sync_restart = 1'b0;
    cfg_load = 1'b0; cfg_channel = '0; cfg_half_period = '0;
    enable3 = 3'b111; cfg_load3 = 1'b0; cfg_channel3 = '0; cfg_half_period3 = '0;

    // Reset state
    repeat (2) @(posedge clk_FPGA);
    #1;
    chk("rst_clk",     32'(clock_signal), 32'h0);
    chk("rst_tick",    32'(tick),         32'h0);
    chk("rst_pending", 32'(cfg_pending),  32'h0);
    chk("rst_error",   32'(cfg_error),    32'h0);
    reset = 1'b0;

    // Default half-period 5: rise after 5 edges, period 10
    step(4);  chk("def_low4",    32'(clock_signal), 32'h0);
    step(1);  chk("def_rise",    32'(clock_signal), 32'hF);
              chk("def_tick",    32'(tick),         32'hF);
    step(1);  chk("def_tick_off",32'(tick),         32'h0);
    step(3);  chk("def_high9",   32'(clock_signal), 32'hF);
    step(1);  chk("def_fall10",  32'(clock_signal), 32'h0);
    step(4);  chk("def_low14",   32'(clock_signal), 32'h0);
    step(1);  chk("def_rise15",  32'(clock_signal), 32'hF);
              chk("def_tick15",  32'(tick),         32'hF);

    // Reload ch1 = 3 mid-half (edge 17); applies at edge 20
    step(2);  load(2'd1, 32'd3);
    step(1);  cfg_load = 1'b0;
              chk("rl_pend18",   32'(cfg_pending),  32'h2);
              chk("rl_err18",    32'(cfg_error),    32'h0);
    step(1);  chk("rl_pend19",   32'(cfg_pending),  32'h2);
              chk("rl_clk19",    32'(clock_signal), 32'hF);
    step(1);  chk("rl_pend20",   32'(cfg_pending),  32'h0);
              chk("rl_clk20",    32'(clock_signal), 32'h0);
    step(2);  chk("rl_clk22",    32'(clock_signal), 32'h0);
    step(1);  chk("rl_clk23",    32'(clock_signal), 32'h2);
              chk("rl_tick23",   32'(tick),         32'h2);
    step(2);  chk("rl_clk25",    32'(clock_signal), 32'hF);
              chk("rl_tick25",   32'(tick),         32'hD);
    step(1);  chk("rl_clk26",    32'(clock_signal), 32'hD);

    // Reject zero half-period on ch0
    load(2'd0, 32'd0);
    step(1);  cfg_load = 1'b0;
              chk("rej0_err",    32'(cfg_error),    32'h1);
              chk("rej0_pend",   32'(cfg_pending),  32'h0);
    step(1);  chk("rej0_err_off",32'(cfg_error),    32'h0);
              chk("rej0_clk28",  32'(clock_signal), 32'hD);
    step(1);  chk("rej0_clk29",  32'(clock_signal), 32'hF);
              chk("rej0_tick29", 32'(tick),         32'h2);
    step(1);  chk("rej0_clk30",  32'(clock_signal), 32'h2);

    // Reject channel 3 on the three-channel instance, then a valid load
    cfg_load3 = 1'b1; cfg_channel3 = 2'd3; cfg_half_period3 = 32'd7;
    step(1);  chk("rejch_err",   32'(cfg_error3),   32'h1);
              chk("rejch_pend",  32'(cfg_pending3), 32'h0);
              chk("rejch_main",  32'(cfg_error),    32'h0);
    cfg_channel3 = 2'd2;
    step(1);  cfg_load3 = 1'b0;
              chk("ok3_err",     32'(cfg_error3),   32'h0);
              chk("ok3_pend",    32'(cfg_pending3), 32'h4);
              chk("rej_clk32",   32'(clock_signal), 32'h0);

    // Minimum divisor on ch2, applied at its boundary at edge 35
    load(2'd2, 32'd1);
    step(1);  cfg_load = 1'b0;
              chk("min_pend33",  32'(cfg_pending),  32'h4);
    step(1);  chk("min_pend34",  32'(cfg_pending),  32'h4);
              chk("min_clk34",   32'(clock_signal), 32'h0);
    step(1);  chk("min_clk35",   32'(clock_signal), 32'hF);
              chk("min_tick35",  32'(tick),         32'hF);
              chk("min_pend35",  32'(cfg_pending),  32'h0);
    step(1);  chk("min_clk36",   32'(clock_signal), 32'hB);
              chk("min_tick36",  32'(tick),         32'h0);
    step(1);  chk("min_clk37",   32'(clock_signal), 32'hF);
              chk("min_tick37",  32'(tick),         32'h4);
    step(1);  chk("min_clk38",   32'(clock_signal), 32'h9);
              chk("min_tick38",  32'(tick),         32'h0);

    // Set up 3,5,7,4 with a pending load carried into the restart
    load(2'd1, 32'd5);
    step(1);  chk("rs_pend39",   32'(cfg_pending),  32'h2);
              chk("rs_clk39",    32'(clock_signal), 32'hD);
              chk("rs_tick39",   32'(tick),         32'h4);
    load(2'd0, 32'd3);
    step(1);  chk("rs_pend40",   32'(cfg_pending),  32'h2);
              chk("rs_clk40",    32'(clock_signal), 32'h0);
    load(2'd3, 32'd4);
    step(1);  chk("rs_pend41",   32'(cfg_pending),  32'h8);
              chk("rs_clk41",    32'(clock_signal), 32'h6);
              chk("rs_tick41",   32'(tick),         32'h6);
    load(2'd2, 32'd7);
    sync_restart = 1'b1;
    step(1);  cfg_load = 1'b0; sync_restart = 1'b0;
              chk("rs_clk42",    32'(clock_signal), 32'h0);
              chk("rs_tick42",   32'(tick),         32'h0);
              chk("rs_pend42",   32'(cfg_pending),  32'h0);
    step(2);  chk("rs_clk44",    32'(clock_signal), 32'h0);
    step(1);  chk("rs_clk45",    32'(clock_signal), 32'h1);
              chk("rs_tick45",   32'(tick),         32'h1);
    step(1);  chk("rs_clk46",    32'(clock_signal), 32'h9);
              chk("rs_tick46",   32'(tick),         32'h8);
    step(1);  chk("rs_clk47",    32'(clock_signal), 32'hB);
              chk("rs_tick47",   32'(tick),         32'h2);
    step(1);  chk("rs_clk48",    32'(clock_signal), 32'hA);
    step(1);  chk("rs_clk49",    32'(clock_signal), 32'hE);
              chk("rs_tick49",   32'(tick),         32'h4);

    // Disable ch0 for one cycle; re-enable rises after 3 cycles
    enable = 4'hE;
    step(1);  chk("dis_clk50",   32'(clock_signal), 32'h6);
    enable = 4'hF;
    step(1);  chk("dis_clk51",   32'(clock_signal), 32'h6);
    step(1);  chk("dis_clk52",   32'(clock_signal), 32'h4);
    step(1);  chk("dis_clk53",   32'(clock_signal), 32'h5);
              chk("dis_tick53",  32'(tick),         32'h1);

    // Mid-run async reset while ch0 (active 3) is high and ch1 has a pending load
    load(2'd1, 32'd9);
    step(1);  cfg_load = 1'b0;
              chk("mr_pend54",   32'(cfg_pending),  32'h2);
              chk("mr_clk54",    32'(clock_signal), 32'hD);
              chk("mr_tick54",   32'(tick),         32'h8);
    #1 reset = 1'b1;
    #1;       chk("mr_async_clk",  32'(clock_signal), 32'h0);
              chk("mr_async_tick", 32'(tick),         32'h0);
              chk("mr_async_pend", 32'(cfg_pending),  32'h0);
    step(2);  chk("mr_hold_clk", 32'(clock_signal), 32'h0);
    reset = 1'b0;
    step(4);  chk("mr_low4",     32'(clock_signal), 32'h0);
              chk("mr_pend",     32'(cfg_pending),  32'h0);
    step(1);  chk("mr_rise5",    32'(clock_signal), 32'hF);
              chk("mr_tick5",    32'(tick),         32'hF);
    step(4);  chk("mr_high9",    32'(clock_signal), 32'hF);
    step(1);  chk("mr_fall10",   32'(clock_signal), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
